somador_pipe: RTL



---
 rtl/somador_pkg.sv | 11 +
 rtl/somador_slice.sv | 23 ++
 rtl/somador_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/somador_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package somador_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/somador_slice.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB.
module somador_slice
  import somador_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s    = full[CHUNK-1:0];
  assign co   = full[CHUNK];
  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the XOR.
  assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/somador_pipe.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit slice per stage, carry ripples
// between stages, valid/ready handshake with a single global enable.
module somador_pipe
  import somador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o,
  output logic             ov_o
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("somador_pipe: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             carry0;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign en         = in_ready_o;
  assign b_eff      = (sub_i == OP_SUB) ? ~b_i : b_i;
  assign carry0     = (sub_i == OP_SUB) ? ~cin_i : cin_i;

  // Stage k keeps the not-yet-added operand bits (shifted down so the next slice
  // sits at bit 0) and the finished low result bits, growing by CHUNK per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int OW = WIDTH - k * CHUNK;
    localparam int RW = OW - CHUNK;
    localparam int DW = (k + 1) * CHUNK;

    logic [OW-1:0]    a_op;
    logic [OW-1:0]    b_op;
    logic             c_op;
    logic             vld_op;
    logic [CHUNK-1:0] sum;
    logic             co;
    logic             cmsb;
    logic [DW-1:0]    s_nxt;
    logic [DW-1:0]    s_p;
    logic             c_p;
    logic             vld_p;

    if (k == 0) begin : g_src
      assign a_op   = a_i;
      assign b_op   = b_eff;
      assign c_op   = carry0;
      assign vld_op = in_valid_i;
      assign s_nxt  = sum;
    end else begin : g_src
      assign a_op   = g_stg[k-1].g_rest.a_p;
      assign b_op   = g_stg[k-1].g_rest.b_p;
      assign c_op   = g_stg[k-1].c_p;
      assign vld_op = g_stg[k-1].vld_p;
      assign s_nxt  = {sum, g_stg[k-1].s_p};
    end

    somador_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_op[CHUNK-1:0]),
      .b    (b_op[CHUNK-1:0]),
      .cin  (c_op),
      .s    (sum),
      .co   (co),
      .cmsb (cmsb)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_p <= 1'b0;
        c_p   <= 1'b0;
        s_p   <= '0;
      end else if (en) begin
        vld_p <= vld_op;
        c_p   <= co;
        s_p   <= s_nxt;
      end
    end

    if (RW > 0) begin : g_rest
      logic [RW-1:0] a_p;
      logic [RW-1:0] b_p;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_p <= '0;
          b_p <= '0;
        end else if (en) begin
          a_p <= a_op[OW-1:CHUNK];
          b_p <= b_op[OW-1:CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ov_p;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ov_p <= 1'b0;
        end else if (en) begin
          ov_p <= co ^ cmsb;
        end
      end
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = cmsb;
    end
  end

  assign out_valid_o = g_stg[STAGES-1].vld_p;
  assign s_o         = g_stg[STAGES-1].s_p;
  assign co_o        = g_stg[STAGES-1].c_p;
  assign ov_o        = g_stg[STAGES-1].g_last.ov_p;

endmodule
